dl11_serial_regs: RTL and testbench

//  DL11-style console register interface between the CPU bus and the UART pair.

---
 rtl/dl11_serial_regs_pkg.sv | 53 +++++
 rtl/dl11_rx_fifo.sv | 54 +++++
 rtl/dl11_serial_regs.sv | 191 +++++++++++++++++++
 tb/tb_dl11_serial_regs.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl11_serial_regs_pkg.sv
// Shared definitions for the DL11 console register slice: register offsets,
// CSR bit positions and small helpers for bus decode and CSR word assembly.
package dl11_serial_regs_pkg;

    typedef enum logic [1:0] {
        REG_RCSR = 2'd0,
        REG_RBUF = 2'd1,
        REG_XCSR = 2'd2,
        REG_XBUF = 2'd3
    } reg_offset_e;

    localparam int BIT_DONE = 7;
    localparam int BIT_IE   = 6;
    localparam int BIT_OVR  = 14;
    localparam int BIT_ERR  = 15;

    // Cycles the transmitter is held not-ready after a send, covering the
    // latency before serial_tx reports busy.
    localparam logic [1:0] TX_HOLD_CYCLES = 2'd2;

    typedef struct packed {
        logic rd_rbuf;
        logic wr_rcsr;
        logic wr_xcsr;
        logic wr_xbuf;
    } bus_access_t;

    function automatic bus_access_t decode_access(
        input logic       sel,
        input logic       rd,
        input logic       wr,
        input logic [1:0] addr
    );
        bus_access_t acc;
        acc         = '0;
        acc.rd_rbuf = sel && rd && (addr == REG_RBUF);
        acc.wr_rcsr = sel && wr && (addr == REG_RCSR);
        acc.wr_xcsr = sel && wr && (addr == REG_XCSR);
        acc.wr_xbuf = sel && wr && (addr == REG_XBUF);
        return acc;
    endfunction

    // Status word layout shared by RCSR and XCSR: a status flag in bit 7 and
    // the interrupt enable in bit 6.
    function automatic logic [15:0] csr_word(input logic status_flag, input logic int_enable);
        logic [15:0] word;
        word           = '0;
        word[BIT_DONE] = status_flag;
        word[BIT_IE]   = int_enable;
        return word;
    endfunction

endpackage

// File: rtl/dl11_rx_fifo.sv
// Small receive FIFO for the DL11 slice. Extra pointer MSB distinguishes full
// from empty; a pop frees a slot for a push in the same cycle.
module dl11_rx_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int         DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Head is visible combinationally so the bus can read RBUF in the same cycle.
    assign dout = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/dl11_serial_regs.sv
// DL11-style console registers: RCSR/RBUF/XCSR/XBUF bus window over a receive
// FIFO fed by serial_rx and a single-byte send path into serial_tx.
module dl11_serial_regs
    import dl11_serial_regs_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        irq_rx,
    output logic        irq_tx,
    input  logic        iack_tx
);

    bus_access_t acc;

    logic       rx_read_reg;
    logic       rx_accept;
    logic       ovr_reg;
    logic       ovr_next;
    logic       rie_reg;
    logic       rie_next;
    logic       overrun;

    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] fifo_head;

    logic       tie_reg;
    logic       tie_next;
    logic [7:0] tx_byte_reg;
    logic [7:0] tx_byte_next;
    logic       tx_send_reg;
    logic [1:0] hold_reg;
    logic [1:0] hold_next;
    logic       tx_ready;
    logic       xbuf_accept;

    logic       ready_prev_reg;
    logic       irq_tx_reg;
    logic       irq_tx_next;
    logic       irq_tx_set;
    logic       irq_tx_clr;

    logic       din_unused;

    assign acc        = decode_access(sel, rd, wr, addr);
    assign din_unused = ^din[15:8];

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    // serial_rx drops ready one edge after our acknowledge, so the cycle
    // following rx_read must not be treated as a new byte.
    assign rx_accept = rx_ready && !rx_read_reg;

    // A same-cycle RBUF read frees a slot on a full FIFO, so no overrun then.
    assign overrun = rx_accept && fifo_full && !acc.rd_rbuf;

    dl11_rx_fifo #(
        .AW (FIFO_AW)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_accept),
        .pop   (acc.rd_rbuf),
        .din   (rx_byte),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        ovr_next = ovr_reg;
        if (acc.rd_rbuf) begin
            ovr_next = 1'b0;
        end else if (overrun) begin
            ovr_next = 1'b1;
        end
    end

    always_comb begin
        rie_next = rie_reg;
        if (acc.wr_rcsr) begin
            rie_next = din[BIT_IE];
        end
    end

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    assign tx_ready    = !tx_busy && (hold_reg == 2'd0);
    assign xbuf_accept = acc.wr_xbuf && tx_ready;

    always_comb begin
        hold_next    = hold_reg;
        tx_byte_next = tx_byte_reg;
        if (xbuf_accept) begin
            hold_next    = TX_HOLD_CYCLES;
            tx_byte_next = din[7:0];
        end else if (hold_reg != 2'd0) begin
            hold_next = hold_reg - 2'd1;
        end
    end

    always_comb begin
        tie_next = tie_reg;
        if (acc.wr_xcsr) begin
            tie_next = din[BIT_IE];
        end
    end

    // Transmit interrupt latches on READY rising with TIE set, or on TIE
    // being enabled while already READY; any clear source overrides a set.
    assign irq_tx_set = (tx_ready && !ready_prev_reg && tie_reg) ||
                        (acc.wr_xcsr && din[BIT_IE] && !tie_reg && tx_ready);
    assign irq_tx_clr = iack_tx || (acc.wr_xcsr && !din[BIT_IE]) || xbuf_accept;

    always_comb begin
        irq_tx_next = irq_tx_reg;
        if (irq_tx_clr) begin
            irq_tx_next = 1'b0;
        end else if (irq_tx_set) begin
            irq_tx_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_read_reg    <= 1'b0;
            ovr_reg        <= 1'b0;
            rie_reg        <= 1'b0;
            tie_reg        <= 1'b0;
            tx_byte_reg    <= 8'h00;
            tx_send_reg    <= 1'b0;
            hold_reg       <= 2'd0;
            irq_tx_reg     <= 1'b0;
            ready_prev_reg <= 1'b1;
        end else begin
            rx_read_reg    <= rx_accept;
            ovr_reg        <= ovr_next;
            rie_reg        <= rie_next;
            tie_reg        <= tie_next;
            tx_byte_reg    <= tx_byte_next;
            tx_send_reg    <= xbuf_accept;
            hold_reg       <= hold_next;
            irq_tx_reg     <= irq_tx_next;
            ready_prev_reg <= tx_ready;
        end
    end

    // ------------------------------------------------------------------
    // Bus read mux and outputs
    // ------------------------------------------------------------------
    always_comb begin
        dout = 16'h0000;
        case (reg_offset_e'(addr))
            REG_RCSR: dout = csr_word(!fifo_empty, rie_reg);
            REG_RBUF: begin
                dout[7:0]     = fifo_head;
                dout[BIT_OVR] = ovr_reg;
                dout[BIT_ERR] = ovr_reg;
            end
            REG_XCSR: dout = csr_word(tx_ready, tie_reg);
            REG_XBUF: dout = {8'h00, tx_byte_reg};
            default:  dout = 16'h0000;
        endcase
    end

    assign rx_read = rx_read_reg;
    assign tx_byte = tx_byte_reg;
    assign tx_send = tx_send_reg;
    assign irq_rx  = rie_reg && !fifo_empty;
    assign irq_tx  = irq_tx_reg;

endmodule

// File: tb/tb_dl11_serial_regs.sv
// Bench for dl11_serial_regs: directed scenarios then random bus/serial traffic,
// all checked against a queue-based behavioural model of the register window.
module tb_dl11_serial_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] din;
    logic [15:0] dout;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        rx_read;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_busy;
    logic        irq_rx;
    logic        irq_tx;
    logic        iack_tx;

    int checks   = 0;
    int failures = 0;

    // serial_tx environment: busy appears two cycles after the send pulse
    logic send_d1;
    int   busy_cnt;
    int   busy_len;

    // behavioural model
    logic [7:0] m_q[$];
    logic       m_ovr, m_rie, m_tie, m_rx_read, m_tx_send, m_irq_tx, m_ready_prev;
    logic [7:0] m_tx_byte;
    int         m_age;

    always #10 clk = ~clk;

    dl11_serial_regs #(.FIFO_AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .din      (din),
        .dout     (dout),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .rx_read  (rx_read),
        .tx_byte  (tx_byte),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .irq_rx   (irq_rx),
        .irq_tx   (irq_tx),
        .iack_tx  (iack_tx)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Transmitter may accept a byte once serial_tx is idle and at least three
    // cycles have passed since the last accepted write.
    function automatic logic m_ready();
        return !tx_busy && (m_age >= 3);
    endfunction

    function automatic logic [15:0] m_dout(input logic [1:0] a);
        logic [15:0] v;
        v = 16'h0000;
        case (a)
            2'd0: v = {8'h00, (m_q.size() > 0), m_rie, 6'b0};
            2'd1: v = {m_ovr, m_ovr, 6'b0, (m_q.size() > 0) ? m_q[0] : 8'h00};
            2'd2: v = {8'h00, m_ready(), m_tie, 6'b0};
            default: v = {8'h00, m_tx_byte};
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovr = 0; m_rie = 0; m_tie = 0; m_rx_read = 0; m_tx_send = 0;
        m_irq_tx = 0; m_ready_prev = 1; m_tx_byte = 8'h00; m_age = 3;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_next();
        logic rdy, rd_rbuf, wr_rcsr, wr_xcsr, wr_xbuf, accept, set_i, clr_i;
        rdy     = m_ready();
        rd_rbuf = sel && rd && (addr == 2'd1);
        wr_rcsr = sel && wr && (addr == 2'd0);
        wr_xcsr = sel && wr && (addr == 2'd2);
        wr_xbuf = sel && wr && (addr == 2'd3);
        accept  = rx_ready && !m_rx_read;
        if (rd_rbuf) begin
            m_ovr = 0;
            if (m_q.size() > 0) void'(m_q.pop_front());
        end
        if (accept) begin
            if (m_q.size() < 4) m_q.push_back(rx_byte);
            else m_ovr = 1;
        end
        m_rx_read = accept;
        set_i = (rdy && !m_ready_prev && m_tie) || (wr_xcsr && din[6] && !m_tie && rdy);
        clr_i = iack_tx || (wr_xcsr && !din[6]) || (wr_xbuf && rdy);
        if (clr_i) m_irq_tx = 0;
        else if (set_i) m_irq_tx = 1;
        m_ready_prev = rdy;
        if (wr_rcsr) m_rie = din[6];
        if (wr_xcsr) m_tie = din[6];
        if (wr_xbuf && rdy) begin
            m_tx_byte = din[7:0];
            m_tx_send = 1;
            m_age     = 1;
        end else begin
            m_tx_send = 0;
            if (m_age < 3) m_age++;
        end
    endtask

    task automatic check_all();
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check_val($sformatf("dout[%0d]", a), dout, m_dout(2'(a)));
        end
        check_val("rx_read", {15'b0, rx_read}, {15'b0, m_rx_read});
        check_val("tx_send", {15'b0, tx_send}, {15'b0, m_tx_send});
        check_val("tx_byte", {8'b0, tx_byte}, {8'b0, m_tx_byte});
        check_val("irq_rx", {15'b0, irq_rx}, {15'b0, (m_rie && m_q.size() > 0)});
        check_val("irq_tx", {15'b0, irq_tx}, {15'b0, m_irq_tx});
    endtask

    task automatic env_reset();
        send_d1 = 0; busy_cnt = 0; tx_busy = 0;
    endtask

    // One clock: model update, edge, serial_rx/serial_tx reactions, checks.
    task automatic step();
        logic rr, ts;
        rr = rx_read;
        ts = tx_send;
        model_next();
        @(posedge clk);
        #1;
        if (rr) rx_ready = 0;
        if (busy_cnt > 0) busy_cnt--;
        if (send_d1) busy_cnt = busy_len;
        send_d1 = ts;
        tx_busy = (busy_cnt > 0);
        sel = 0; rd = 0; wr = 0; iack_tx = 0;
        check_all();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        sel = 1; wr = 1; addr = a; din = d;
        step();
    endtask

    task automatic bus_rd(input logic [1:0] a);
        sel = 1; rd = 1; addr = a;
        step();
    endtask

    task automatic offer(input logic [7:0] b);
        rx_byte = b; rx_ready = 1;
        step();
        step();
    endtask

    task automatic peek(input logic [1:0] a, output logic [15:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    initial begin
        logic [15:0] v;
        logic        found;

        reset = 0; sel = 0; addr = 0; rd = 0; wr = 0; din = 0;
        rx_byte = 0; rx_ready = 0; iack_tx = 0; busy_len = 4;
        env_reset();
        model_reset();
        repeat (2) @(negedge clk);
        peek(2'd0, v); check_val("rst_rcsr", v, 16'h0000);
        peek(2'd2, v); check_val("rst_xcsr", v, 16'h0080);
        check_val("rst_tx_send", {15'b0, tx_send}, 16'h0000);
        reset = 1;
        step();

        // 1: single byte
        rx_byte = 8'hA5; rx_ready = 1;
        step();
        check_val("t1_rx_read_hi", {15'b0, rx_read}, 16'h0001);
        step();
        check_val("t1_rx_read_lo", {15'b0, rx_read}, 16'h0000);
        peek(2'd0, v); check_val("t1_rcsr", v, 16'h0080);
        peek(2'd1, v); check_val("t1_rbuf", v, 16'h00A5);
        bus_rd(2'd1);
        peek(2'd0, v); check_val("t1_rcsr_empty", v, 16'h0000);

        // 2: overrun
        for (int i = 1; i <= 5; i++) offer(8'(i));
        peek(2'd1, v); check_val("t2_rbuf_ovr", v, 16'hC001);
        for (int i = 2; i <= 4; i++) begin
            bus_rd(2'd1);
            peek(2'd1, v); check_val("t2_rbuf_next", v, 16'(i));
        end
        bus_rd(2'd1);
        peek(2'd0, v); check_val("t2_rcsr_drained", v, 16'h0000);

        // 3: receive interrupt
        bus_wr(2'd0, 16'h0040);
        check_val("t3_irq_rx_empty", {15'b0, irq_rx}, 16'h0000);
        offer(8'h3C);
        check_val("t3_irq_rx_set", {15'b0, irq_rx}, 16'h0001);
        bus_rd(2'd1);
        check_val("t3_irq_rx_clr", {15'b0, irq_rx}, 16'h0000);
        bus_wr(2'd0, 16'h0000);

        // 4: transmit
        busy_len = 4;
        bus_wr(2'd3, 16'h0155);
        check_val("t4_tx_send", {15'b0, tx_send}, 16'h0001);
        check_val("t4_tx_byte", {8'b0, tx_byte}, 16'h0055);
        step();
        check_val("t4_tx_send_1cyc", {15'b0, tx_send}, 16'h0000);
        peek(2'd2, v); check_val("t4_xcsr_busy", v, 16'h0000);
        bus_wr(2'd3, 16'h00AA);
        check_val("t4_drop_send", {15'b0, tx_send}, 16'h0000);
        check_val("t4_drop_byte", {8'b0, tx_byte}, 16'h0055);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            peek(2'd2, v);
            found = v[7];
        end
        check_val("t4_ready_return", {15'b0, found}, 16'h0001);

        // 5: transmit interrupt
        bus_wr(2'd2, 16'h0040);
        check_val("t5_irq_tx_set", {15'b0, irq_tx}, 16'h0001);
        iack_tx = 1;
        step();
        check_val("t5_irq_tx_ack", {15'b0, irq_tx}, 16'h0000);
        bus_wr(2'd3, 16'h0011);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            peek(2'd2, v);
            found = v[7];
        end
        check_val("t5_ready_return", {15'b0, found}, 16'h0001);
        step();
        check_val("t5_irq_tx_again", {15'b0, irq_tx}, 16'h0001);

        // 6: reset mid-operation with byte in flight
        bus_wr(2'd0, 16'h0040);
        for (int i = 0; i < 5; i++) offer(8'h10 + 8'(i));
        rx_byte = 8'h77; rx_ready = 1;
        #3;
        reset = 0;
        model_reset();
        env_reset();
        peek(2'd0, v); check_val("t6_rcsr", v, 16'h0000);
        peek(2'd1, v); check_val("t6_rbuf", v, 16'h0000);
        peek(2'd2, v); check_val("t6_xcsr", v, 16'h0080);
        peek(2'd3, v); check_val("t6_xbuf", v, 16'h0000);
        check_val("t6_irqs", {14'b0, irq_rx, irq_tx}, 16'h0000);
        check_val("t6_handshakes", {14'b0, rx_read, tx_send}, 16'h0000);
        #1;
        reset = 1;
        step();
        step();
        peek(2'd1, v); check_val("t6_inflight", v, 16'h0077);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if (!rx_ready && $urandom_range(0, 3) == 0) begin
                rx_byte  = 8'($urandom);
                rx_ready = 1;
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    sel  = 1;
                    addr = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 1) rd = 1;
                    else begin
                        wr  = 1;
                        din = 16'($urandom);
                    end
                end
                5: begin
                    addr = 2'($urandom_range(0, 3));
                    rd   = 1;
                    wr   = ($urandom_range(0, 1) == 1);
                    din  = 16'($urandom);
                end
                default: ;
            endcase
            iack_tx  = ($urandom_range(0, 7) == 0);
            busy_len = $urandom_range(1, 5);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
